// File: rtl/dcache_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : dcache_port_arbiter
// Purpose : Two-port round-robin arbiter in front of a single-operation dcache.
//           Optional WAIT-state timeout abort enabled by DCACHE_ARB_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
module dcache_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req0_valid,
    input  logic            i_req0_rw,
    input  logic [XLEN-1:0] i_req0_addr,
    input  logic [XLEN-1:0] i_req0_wdata,
    input  logic            i_req1_valid,
    input  logic            i_req1_rw,
    input  logic [XLEN-1:0] i_req1_addr,
    input  logic [XLEN-1:0] i_req1_wdata,
    output logic            o_ack0,
    output logic            o_ack1,
    output logic            o_done0,
    output logic            o_done1,
    output logic [XLEN-1:0] o_rdata0,
    output logic [XLEN-1:0] o_rdata1,
    output logic            o_error0,
    output logic            o_error1,
    output logic            o_cache_start,
    output logic            o_cache_rw,
    output logic [XLEN-1:0] o_cache_addr,
    output logic [XLEN-1:0] o_cache_wdata,
    input  logic            i_cache_done,
    input  logic [XLEN-1:0] i_cache_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_grant;
    logic            r_last;
    logic            r_rw;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_error;
    logic            w_any;
    logic            w_win;
    logic            w_timeout;

    assign w_any = i_req0_valid | i_req1_valid;
    // On a tie the port not served last wins; otherwise the lone requester.
    assign w_win = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;

`ifdef DCACHE_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] r_tcnt;

    // A done arriving on the limit cycle takes priority over the abort.
    assign w_timeout = (r_state == S_WAIT) && !i_cache_done &&
                       (r_tcnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tcnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tcnt <= '0;
        end else if (r_state == S_WAIT && !i_cache_done) begin
            r_tcnt <= r_tcnt + c_cnt_w'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (i_cache_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_rw    <= w_win ? i_req1_rw    : i_req0_rw;
                        r_addr  <= w_win ? i_req1_addr  : i_req0_addr;
                        r_wdata <= w_win ? i_req1_wdata : i_req0_wdata;
                    end
                end
                S_WAIT: begin
                    if (i_cache_done) begin
                        r_rdata <= r_rw ? '0 : i_cache_data;
                        r_error <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_error <= 1'b1;
                    end
                end
                S_RESP:  r_last <= r_grant;
                default: ;
            endcase
        end
    end

    assign o_cache_start = (r_state == S_ISSUE);
    assign o_ack0        = (r_state == S_ISSUE) & ~r_grant;
    assign o_ack1        = (r_state == S_ISSUE) &  r_grant;
    assign o_done0       = (r_state == S_RESP)  & ~r_grant;
    assign o_done1       = (r_state == S_RESP)  &  r_grant;
    assign o_rdata0      = o_done0 ? r_rdata : '0;
    assign o_rdata1      = o_done1 ? r_rdata : '0;
    assign o_error0      = o_done0 & r_error;
    assign o_error1      = o_done1 & r_error;
    assign o_cache_rw    = r_rw;
    assign o_cache_addr  = r_addr;
    assign o_cache_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_dcache_port_arbiter
// Purpose : Scoreboard bench for dcache_port_arbiter with a latency-programmable
//           cache model. Timeout cases run when DCACHE_ARB_TIMEOUT_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module tb_dcache_port_arbiter;

    localparam int          XLEN = 32;
    localparam int          TO   = 8;
    localparam logic [31:0] KEY  = 32'hDEADBFEF;

    typedef struct {
        bit          port;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } txn_t;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_req0_valid = 1'b0;
    logic            i_req0_rw = 1'b0;
    logic [XLEN-1:0] i_req0_addr = '0;
    logic [XLEN-1:0] i_req0_wdata = '0;
    logic            i_req1_valid = 1'b0;
    logic            i_req1_rw = 1'b0;
    logic [XLEN-1:0] i_req1_addr = '0;
    logic [XLEN-1:0] i_req1_wdata = '0;
    logic            o_ack0, o_ack1, o_done0, o_done1, o_error0, o_error1;
    logic [XLEN-1:0] o_rdata0, o_rdata1;
    logic            o_cache_start, o_cache_rw;
    logic [XLEN-1:0] o_cache_addr, o_cache_wdata;
    logic            i_cache_done;
    logic [XLEN-1:0] i_cache_data;

    logic r_cache_done = 1'b0;
    logic r_stray = 1'b0;
    int   cache_lat = 1;
    bit   cache_never = 1'b0;

    txn_t sb[$];
    txn_t q0[$];
    txn_t q1[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_done = 0;

    assign i_cache_done = r_cache_done | r_stray;
    assign i_cache_data = o_cache_addr ^ KEY;

    dcache_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) u_dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0_valid(i_req0_valid), .i_req0_rw(i_req0_rw),
        .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
        .i_req1_valid(i_req1_valid), .i_req1_rw(i_req1_rw),
        .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
        .o_ack0(o_ack0), .o_ack1(o_ack1), .o_done0(o_done0), .o_done1(o_done1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_error0(o_error0), .o_error1(o_error1),
        .o_cache_start(o_cache_start), .o_cache_rw(o_cache_rw),
        .o_cache_addr(o_cache_addr), .o_cache_wdata(o_cache_wdata),
        .i_cache_done(i_cache_done), .i_cache_data(i_cache_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit port, input bit rw, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat, input bit exp_err);
        txn_t t;
        t.port  = port;
        t.rw    = rw;
        t.addr  = addr;
        t.wdata = wdata;
        t.err   = exp_err;
        t.lat   = exp_lat;
        t.rdata = (rw || exp_err) ? 32'h0 : (addr ^ KEY);
        if (port) q1.push_back(t);
        else      q0.push_back(t);
        sb.push_back(t);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge i_clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {52'd0, o_ack0, o_ack1, o_done0, o_done1, o_error0, o_error1,
                    o_cache_start, o_cache_rw, |o_rdata0, |o_rdata1,
                    |o_cache_addr, |o_cache_wdata}, 64'd0);
    endtask

    // Requesters: present the queue head, retire it once acknowledged.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_req0_valid && o_ack0) void'(q0.pop_front());
            if (q0.size() != 0) begin
                i_req0_valid = 1'b1; i_req0_rw = q0[0].rw;
                i_req0_addr = q0[0].addr; i_req0_wdata = q0[0].wdata;
            end else begin
                i_req0_valid = 1'b0; i_req0_rw = 1'b0; i_req0_addr = '0; i_req0_wdata = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (i_req1_valid && o_ack1) void'(q1.pop_front());
            if (q1.size() != 0) begin
                i_req1_valid = 1'b1; i_req1_rw = q1[0].rw;
                i_req1_addr = q1[0].addr; i_req1_wdata = q1[0].wdata;
            end else begin
                i_req1_valid = 1'b0; i_req1_rw = 1'b0; i_req1_addr = '0; i_req1_wdata = '0;
            end
        end
    end

    // Cache model: done pulse cache_lat cycles after the start pulse.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_cache_start && !i_reset) begin
                repeat (cache_lat) @(negedge i_clk);
                if (!cache_never) begin
                    r_cache_done = 1'b1;
                    @(negedge i_clk);
                    r_cache_done = 1'b0;
                end
            end
        end
    end

    // Monitor: match start/done activity against the scoreboard head.
    initial begin
        txn_t cur;
        bit   active = 1'b0;
        int   cyc = 0;
        int   t0 = 0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_reset) begin
                sb.delete();
                active = 1'b0;
            end else begin
                if (o_ack0 | o_ack1)   check("ack_onehot", 64'(o_ack0 & o_ack1), 64'd0);
                if (o_done0 | o_done1) check("done_onehot", 64'(o_done0 & o_done1), 64'd0);
                if (o_cache_start) begin
                    if (sb.size() == 0) begin
                        check("unexpected_start", 64'd1, 64'd0);
                    end else begin
                        cur = sb[0];
                        active = 1'b1;
                        t0 = cyc;
                        check("start_ack", 64'({o_ack1, o_ack0}), cur.port ? 64'd2 : 64'd1);
                        check("cache_rw", 64'(o_cache_rw), 64'(cur.rw));
                    end
                end
                if (active) begin
                    check("cache_addr", 64'(o_cache_addr), 64'(cur.addr));
                    check("cache_wdata", 64'(o_cache_wdata), 64'(cur.wdata));
                end
                if (o_done0 | o_done1) begin
                    if (!active) begin
                        check("spurious_done", 64'd1, 64'd0);
                    end else begin
                        check("done_port", 64'({o_done1, o_done0}), cur.port ? 64'd2 : 64'd1);
                        check("rdata", 64'(cur.port ? o_rdata1 : o_rdata0), 64'(cur.rdata));
                        check("error", 64'(cur.port ? o_error1 : o_error0), 64'(cur.err));
                        check("other_rdata", 64'(cur.port ? o_rdata0 : o_rdata1), 64'd0);
                        check("latency", 64'(cyc - t0), 64'(cur.lat));
                        void'(sb.pop_front());
                        active = 1'b0;
                        n_done++;
                    end
                end else if (active) begin
                    check("rdata_outside_done", {o_rdata0, o_rdata1}, 64'd0);
                    check("error_outside_done", 64'({o_error0, o_error1}), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nd0;

        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check_quiet("reset_outputs");

        // Stray cache done while idle
        @(posedge i_clk); #1 r_stray = 1'b1;
        @(posedge i_clk); #1 r_stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check_quiet("stray_idle");
        end

        // Both ports held valid: grants alternate starting with port 0
        cache_lat = 1;
        @(posedge i_clk); #1;
        send(1'b0, 1'b0, 32'h0000_1000, 32'h0, 2, 1'b0);
        send(1'b1, 1'b0, 32'h0000_2000, 32'h0, 2, 1'b0);
        send(1'b0, 1'b0, 32'h0000_1004, 32'h0, 2, 1'b0);
        send(1'b1, 1'b0, 32'h0000_2004, 32'h0, 2, 1'b0);
        drain(60);

        // Minimum-latency read on port 0
        @(posedge i_clk); #1;
        send(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2, 1'b0);
        @(negedge i_clk);
        k = 0;
        while (!o_ack0 && k < 10) begin
            @(negedge i_clk);
            k++;
        end
        check("ack_latency", 64'(k), 64'd1);
        drain(20);

        // Port 1 write with a slow cache
        cache_lat = 4;
        @(posedge i_clk); #1;
        send(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 5, 1'b0);
        drain(30);

`ifdef DCACHE_ARB_TIMEOUT_EN
        cache_never = 1'b1;
        @(posedge i_clk); #1;
        send(1'b0, 1'b0, 32'h0000_0300, 32'h0, TO + 1, 1'b1);
        drain(40);
        cache_never = 1'b0;
        cache_lat = 1;
        @(posedge i_clk); #1;
        send(1'b0, 1'b0, 32'h0000_0304, 32'h0, 2, 1'b0);
        drain(20);
`endif

        // Reset while waiting on the cache, then a late cache done
        cache_lat = 6;
        @(posedge i_clk); #1;
        send(1'b0, 1'b0, 32'h0000_0200, 32'h0, 7, 1'b0);
        k = 0;
        while (!o_cache_start && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check("rst_start_seen", 64'(o_cache_start), 64'd1);
        @(posedge i_clk); #1 i_reset = 1'b1;
        @(posedge i_clk); #1 i_reset = 1'b0;
        nd0 = n_done;
        @(negedge i_clk);
        check_quiet("rst_wait_outputs");
        repeat (12) @(negedge i_clk);
        check("rst_no_done", 64'(n_done - nd0), 64'd0);
        check_quiet("rst_late_done_outputs");

        // Recovery after the aborted transaction
        cache_lat = 2;
        @(posedge i_clk); #1;
        send(1'b1, 1'b0, 32'h0000_0500, 32'h0, 3, 1'b0);
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before a timeout abort (only used with DCACHE_ARB_TIMEOUT_EN).
REQ-003 i_clk  in  1  clock; all state changes on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_req0_valid / i_req1_valid  in  1 each  request pending; port 0 = memory stage, port 1 = secondary requester (page walker/debug).
REQ-006 i_req0_rw / i_req1_rw  in  1 each  0 = read, 1 = write.
REQ-007 i_req0_addr / i_req1_addr  in  XLEN each  byte address.
REQ-008 i_req0_wdata / i_req1_wdata  in  XLEN each  write data.
REQ-009 o_ack0 / o_ack1  out  1 each  one-cycle pulse: request latched, requester may drop valid.
REQ-010 o_done0 / o_done1  out  1 each  one-cycle completion pulse.
REQ-011 o_rdata0 / o_rdata1  out  XLEN each  read data, valid while matching o_done pulses.
REQ-012 o_error0 / o_error1  out  1 each  timeout flag, valid with matching o_done.
REQ-013 o_cache_start  out  1  one-cycle pulse launching a cache operation.
REQ-014 o_cache_rw, o_cache_addr, o_cache_wdata  out  1/XLEN/XLEN  latched request, stable from ISSUE through WAIT.
REQ-015 i_cache_done  in  1  cache operation complete; i_cache_data  in  XLEN  read result valid with it.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-017 IDLE: if any valid, latch winner's rw/addr/wdata and grant id, go ISSUE; else stay.
REQ-018 Arbitration round-robin: both valid -> port not served last wins; one valid -> that port wins.
REQ-019 ISSUE: pulse o_cache_start and o_ackN (granted port) for exactly one cycle, go WAIT.
REQ-020 WAIT: on i_cache_done, latch i_cache_data (reads; writes latch 0), go RESP; else stay.
REQ-021 RESP: pulse o_doneN one cycle with o_rdataN/o_errorN, update last-served pointer to N, go IDLE.
REQ-022 Minimum latency: valid in IDLE at cycle 0 -> ack/start cycle 1 -> done sampled cycle 2 -> o_doneN cycle 3.
REQ-023 Requester holds valid and payload stable until o_ackN; a valid still high after ack is a new request.
REQ-024 i_cache_done in IDLE, ISSUE or RESP ignored; no state or output effect.
REQ-025 o_rdataN/o_errorN are 0 for the non-granted port and outside o_doneN cycles.
REQ-026 At most one of o_ack0/o_ack1 and one of o_done0/o_done1 asserted per cycle.

Reset
REQ-027 Reset (any state, mid-operation included) -> IDLE; all outputs 0; latched request 0; timeout counter 0; last-served pointer = port 1 (port 0 wins first tie).
REQ-028 Transaction aborted by reset produces no o_done; a late i_cache_done after reset is ignored per REQ-024.

Configuration
REQ-029 Macro DCACHE_ARB_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without i_cache_done; on reaching TIMEOUT_CYCLES go RESP with o_errorN=1, o_rdataN=0.
REQ-030 DCACHE_ARB_TIMEOUT_EN undefined: no counter, WAIT lasts indefinitely, o_error0/o_error1 tied 0.
REQ-031 Done and timeout in the same cycle: done wins, o_errorN=0.

Verification
REQ-032 Single read port 0 addr 0x100, cache done 1 cycle after start with data 0xDEADBEEF -> o_ack0 cycle 1, o_done0 cycle 3, o_rdata0=0xDEADBEEF, o_error0=0.
REQ-033 Both ports valid from reset, held 4 transactions -> grants 0,1,0,1; never two acks/dones same cycle.
REQ-034 Port 1 write addr 0x40 wdata 0x12345678 -> o_cache_rw=1, addr/wdata stable every WAIT cycle, o_done1 with o_rdata1=0.
REQ-035 Reset asserted in WAIT, then i_cache_done pulsed -> state IDLE, no o_done pulse, all outputs 0.
REQ-036 With DCACHE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, cache never done -> o_done0 with o_error0=1 after 8 WAIT cycles; next request served normally.
REQ-037 Stray i_cache_done in IDLE with no valid -> no state change, no outputs.
